// File: rtl/bepu_periph_hub.sv
// Back-end peripheral hub: per-channel write FIFOs with valid/ready drain, shadow read-back
// and FEPU stall. Optional dropped-write counter enabled by defining BEPU_OVF_CNT_EN.
module bepu_periph_hub #(
   parameter int N_CH       = 4,
   parameter int DW         = 32,
   parameter int AW         = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_CH-1:0]    select,
   input  logic               FEPU_BEPU_w,
   input  logic               FEPU_BEPU_r,
   input  logic [DW-1:0]      FEPU_BEPU_data,
   input  logic [AW-1:0]      FEPU_BEPU_addr,
   output logic [DW-1:0]      BEPU_FEPU_data,
   output logic               BEPU_FEPU_rvalid,
   output logic               bepu_busy,
   output logic [N_CH-1:0]    ch_valid,
   output logic [N_CH*DW-1:0] ch_data,
   output logic [N_CH*AW-1:0] ch_addr,
   input  logic [N_CH-1:0]    ch_ready,
   output logic               sel_err,
   output logic [15:0]        ovf_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   logic [N_CH-1:0]    full;
   logic [N_CH-1:0]    push;
   logic [N_CH-1:0]    pop;
   logic [N_CH*DW-1:0] shadow_flat;
   logic [DW-1:0]      rd_mux;
   logic               sel_none;
   logic               sel_onehot;
   logic               sel_multi;

   assign sel_none   = (select == '0);
   assign sel_onehot = !sel_none && ((select & (select - N_CH'(1))) == '0);
   assign sel_multi  = !sel_none && !sel_onehot;

   // Full is the pre-pop state, so a same-cycle pop never lets a full FIFO take a push.
   assign bepu_busy = FEPU_BEPU_w & (|(select & full));

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      logic [PW-1:0]    wr_ptr;
      logic [PW-1:0]    rd_ptr;
      logic [CW-1:0]    count;
      logic [DW-1:0]    shadow;
      logic [AW+DW-1:0] mem [FIFO_DEPTH];

      assign full[g]     = (count == FULL_CNT);
      assign ch_valid[g] = (count != '0);
      assign push[g]     = FEPU_BEPU_w & sel_onehot & select[g] & ~full[g];
      assign pop[g]      = ch_valid[g] & ch_ready[g];

      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            shadow <= '0;
         end else begin
            if (push[g]) begin
               wr_ptr <= wr_ptr + PW'(1);
               shadow <= FEPU_BEPU_data;
            end
            if (pop[g]) rd_ptr <= rd_ptr + PW'(1);
            if (push[g] && !pop[g])      count <= count + CW'(1);
            else if (!push[g] && pop[g]) count <= count - CW'(1);
         end
      end

      // NOTE: storage is not reset; entries are only observable once count marks them valid.
      always_ff @(posedge clk) begin
         if (push[g]) mem[wr_ptr] <= {FEPU_BEPU_addr, FEPU_BEPU_data};
      end

      assign ch_data[g*DW +: DW]     = mem[rd_ptr][DW-1:0];
      assign ch_addr[g*AW +: AW]     = mem[rd_ptr][AW+DW-1:DW];
      assign shadow_flat[g*DW +: DW] = shadow;
   end

   // NOTE: combinational blocks assign a default first so no latch is inferred.
   always_comb begin
      rd_mux = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (select[k]) rd_mux = rd_mux | shadow_flat[k*DW +: DW];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         BEPU_FEPU_data   <= '0;
         BEPU_FEPU_rvalid <= 1'b0;
         sel_err          <= 1'b0;
      end else begin
         BEPU_FEPU_rvalid <= FEPU_BEPU_r;
         if (FEPU_BEPU_r) BEPU_FEPU_data <= sel_onehot ? rd_mux : '0;
         if ((FEPU_BEPU_w || FEPU_BEPU_r) && sel_multi) sel_err <= 1'b1;
      end
   end

`ifdef BEPU_OVF_CNT_EN
   logic [N_CH-1:0] prev_wsel;
   logic            drop;

   // A held strobe is a stall, not a drop: only the first busy cycle after no write counts.
   assign drop = FEPU_BEPU_w & sel_onehot & (|(select & full & ~prev_wsel));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_wsel <= '0;
         ovf_count <= '0;
      end else begin
         prev_wsel <= FEPU_BEPU_w ? select : '0;
         if (drop && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
      end
   end
`else
   assign ovf_count = 16'h0000;
`endif

endmodule

// File: tb/tb_bepu_periph_hub.sv
// Bench for bepu_periph_hub: directed vector table, hand-written stall/drop/reset sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_bepu_periph_hub;

   localparam int N_CH  = 4;
   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 4;
`ifdef BEPU_OVF_CNT_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst;
   logic [N_CH-1:0]    select;
   logic               w;
   logic               r;
   logic [DW-1:0]      wdata;
   logic [AW-1:0]      waddr;
   logic [DW-1:0]      rdata;
   logic               rvalid;
   logic               busy;
   logic [N_CH-1:0]    ch_valid;
   logic [N_CH*DW-1:0] ch_data;
   logic [N_CH*AW-1:0] ch_addr;
   logic [N_CH-1:0]    ch_ready;
   logic               sel_err;
   logic [15:0]        ovf_count;

   always #5 clk = ~clk;

   bepu_periph_hub #(.N_CH(N_CH), .DW(DW), .AW(AW), .FIFO_DEPTH(DEPTH)) dut (
      .clk              (clk),
      .rst              (rst),
      .select           (select),
      .FEPU_BEPU_w      (w),
      .FEPU_BEPU_r      (r),
      .FEPU_BEPU_data   (wdata),
      .FEPU_BEPU_addr   (waddr),
      .BEPU_FEPU_data   (rdata),
      .BEPU_FEPU_rvalid (rvalid),
      .bepu_busy        (busy),
      .ch_valid         (ch_valid),
      .ch_data          (ch_data),
      .ch_addr          (ch_addr),
      .ch_ready         (ch_ready),
      .sel_err          (sel_err),
      .ovf_count        (ovf_count)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: one queue of {addr,data} per channel plus the read-back state.
   logic [63:0]     mq [N_CH][$];
   logic [DW-1:0]   m_sh [N_CH];
   logic [DW-1:0]   m_rdata;
   logic            m_rvalid;
   logic            m_sel_err;
   logic [15:0]     m_ovf;
   logic [N_CH-1:0] m_prev;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      w = 1'b0; r = 1'b0; select = '0; ch_ready = '0; wdata = '0; waddr = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      tick();
      check("rst_valid", ch_valid, '0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_sel_err", sel_err, 0);
      check("rst_ovf", ovf_count, 0);
      rst = 1'b1;
      for (int k = 0; k < N_CH; k++) begin
         mq[k].delete();
         m_sh[k] = '0;
      end
      m_rdata = '0; m_rvalid = 1'b0; m_sel_err = 1'b0; m_ovf = '0; m_prev = '0;
   endtask

   task automatic write(input int ch, input logic [31:0] d, input logic [31:0] a);
      w = 1'b1; select = N_CH'(1) << ch; wdata = d; waddr = a;
      tick();
      w = 1'b0; select = '0;
   endtask

   typedef struct {
      logic        w, r;
      logic [3:0]  sel;
      logic [31:0] data, addr;
      logic [3:0]  ready;
      logic        exp_busy;
      logic [3:0]  exp_valid;
      logic        exp_rvalid;
      logic [31:0] exp_rdata;
      logic        exp_sel_err;
      int          head_ch;
      logic [31:0] head_data, head_addr;
   } vec_t;

   function automatic vec_t mk(logic wi, logic ri, logic [3:0] s, logic [31:0] d, logic [31:0] a,
                               logic [3:0] rdy, logic [3:0] v, logic rv, logic [31:0] rd,
                               logic se, int hc, logic [31:0] hd, logic [31:0] ha);
      vec_t t;
      t.w = wi; t.r = ri; t.sel = s; t.data = d; t.addr = a; t.ready = rdy;
      t.exp_busy = 1'b0; t.exp_valid = v; t.exp_rvalid = rv; t.exp_rdata = rd;
      t.exp_sel_err = se; t.head_ch = hc; t.head_data = hd; t.head_addr = ha;
      return t;
   endfunction

   task automatic compare_model();
      for (int k = 0; k < N_CH; k++) begin
         check($sformatf("m_valid%0d", k), ch_valid[k], mq[k].size() != 0);
         if (mq[k].size() != 0) begin
            check($sformatf("m_data%0d", k), ch_data[k*DW +: DW], mq[k][0][31:0]);
            check($sformatf("m_addr%0d", k), ch_addr[k*AW +: AW], mq[k][0][63:32]);
         end
      end
      check("m_rvalid", rvalid, m_rvalid);
      check("m_rdata", rdata, m_rdata);
      check("m_sel_err", sel_err, m_sel_err);
      check("m_ovf", ovf_count, m_ovf);
   endtask

   task automatic rnd_cycle();
      logic [N_CH-1:0] fullv;
      logic            exp_busy;
      int              nsel;
      int              pick;
      if ($urandom_range(0, 1) == 0) begin
         pick = $urandom_range(0, 9);
         w = 1'($urandom_range(0, 1));
         if (pick == 0)      select = '0;
         else if (pick == 1) select = N_CH'($urandom);
         else                select = N_CH'(1) << $urandom_range(0, N_CH - 1);
         wdata = $urandom;
         waddr = $urandom;
      end
      r = ($urandom_range(0, 3) == 0);
      ch_ready = N_CH'($urandom & $urandom);
      #2;
      for (int k = 0; k < N_CH; k++) fullv[k] = (mq[k].size() == DEPTH);
      exp_busy = w && ((select & fullv) != '0);
      check("m_busy", busy, exp_busy);
      nsel = $countones(select);
      if (r) begin
         m_rdata = '0;
         if (nsel == 1)
            for (int k = 0; k < N_CH; k++) if (select[k]) m_rdata = m_sh[k];
      end
      m_rvalid = r;
      for (int k = 0; k < N_CH; k++)
         if (mq[k].size() != 0 && ch_ready[k]) void'(mq[k].pop_front());
      if (w && nsel == 1)
         for (int k = 0; k < N_CH; k++)
            if (select[k] && !fullv[k]) begin
               mq[k].push_back({waddr, wdata});
               m_sh[k] = wdata;
            end
      if (OVF_EN && w && nsel == 1 && ((select & fullv & ~m_prev) != '0) && m_ovf != 16'hFFFF)
         m_ovf = m_ovf + 16'd1;
      m_prev = w ? select : '0;
      if ((w || r) && nsel > 1) m_sel_err = 1'b1;
      tick();
      compare_model();
   endtask

   vec_t vecs [12];

   initial begin
      rst = 1'b0;
      idle_inputs();
      #3;

      // Directed table: basic write/drain, read-back, read-before-write, bad selects.
      vecs[0]  = mk(1, 0, 4'b0001, 32'hA5,       32'h10, 4'b0000, 4'b0001, 0, 32'h0,       0, 0, 32'hA5,       32'h10);
      vecs[1]  = mk(0, 0, 4'b0000, 32'h0,        32'h0,  4'b0001, 4'b0000, 0, 32'h0,       0, -1, 32'h0,       32'h0);
      vecs[2]  = mk(1, 0, 4'b1000, 32'hDEADBEEF, 32'h30, 4'b0000, 4'b1000, 0, 32'h0,       0, 3, 32'hDEADBEEF, 32'h30);
      vecs[3]  = mk(0, 1, 4'b1000, 32'h0,        32'h0,  4'b0000, 4'b1000, 1, 32'hDEADBEEF, 0, 3, 32'hDEADBEEF, 32'h30);
      vecs[4]  = mk(1, 1, 4'b1000, 32'h1,        32'h31, 4'b0000, 4'b1000, 1, 32'hDEADBEEF, 0, 3, 32'hDEADBEEF, 32'h30);
      vecs[5]  = mk(0, 1, 4'b1000, 32'h0,        32'h0,  4'b0000, 4'b1000, 1, 32'h1,       0, -1, 32'h0,       32'h0);
      vecs[6]  = mk(0, 1, 4'b0000, 32'h0,        32'h0,  4'b0000, 4'b1000, 1, 32'h0,       0, -1, 32'h0,       32'h0);
      vecs[7]  = mk(1, 0, 4'b0110, 32'h77,       32'h0,  4'b0000, 4'b1000, 0, 32'h0,       1, -1, 32'h0,       32'h0);
      vecs[8]  = mk(1, 0, 4'b0010, 32'h55,       32'h40, 4'b0000, 4'b1010, 0, 32'h0,       1, 1, 32'h55,       32'h40);
      vecs[9]  = mk(0, 0, 4'b0000, 32'h0,        32'h0,  4'b1111, 4'b1000, 0, 32'h0,       1, 3, 32'h1,        32'h31);
      vecs[10] = mk(0, 0, 4'b0000, 32'h0,        32'h0,  4'b1111, 4'b0000, 0, 32'h0,       1, -1, 32'h0,       32'h0);
      vecs[11] = mk(0, 1, 4'b0011, 32'h0,        32'h0,  4'b0000, 4'b0000, 1, 32'h0,       1, -1, 32'h0,       32'h0);

      do_reset();
      for (int i = 0; i < 12; i++) begin
         w = vecs[i].w; r = vecs[i].r; select = vecs[i].sel;
         wdata = vecs[i].data; waddr = vecs[i].addr; ch_ready = vecs[i].ready;
         #2;
         check($sformatf("v%0d_busy", i), busy, vecs[i].exp_busy);
         tick();
         check($sformatf("v%0d_valid", i), ch_valid, vecs[i].exp_valid);
         check($sformatf("v%0d_rvalid", i), rvalid, vecs[i].exp_rvalid);
         check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
         check($sformatf("v%0d_sel_err", i), sel_err, vecs[i].exp_sel_err);
         if (vecs[i].head_ch >= 0) begin
            check($sformatf("v%0d_head_data", i), ch_data[vecs[i].head_ch*DW +: DW], vecs[i].head_data);
            check($sformatf("v%0d_head_addr", i), ch_addr[vecs[i].head_ch*AW +: AW], vecs[i].head_addr);
         end
      end
      idle_inputs();

      // Full FIFO stall: held write is taken the cycle after a pop, order preserved, no drop.
      do_reset();
      for (int i = 1; i <= 4; i++) write(2, i, 32'h20 + i);
      check("stall_full_valid", ch_valid[2], 1);
      w = 1'b1; select = 4'b0100; wdata = 32'd5; waddr = 32'h25;
      for (int c = 0; c < 3; c++) begin
         #2;
         check("stall_busy_hold", busy, 1);
         tick();
      end
      ch_ready = 4'b0100;
      #2;
      check("stall_busy_pop", busy, 1);
      check("stall_head1", ch_data[2*DW +: DW], 32'd1);
      tick();
      ch_ready = '0;
      #2;
      check("stall_busy_clear", busy, 0);
      tick();
      w = 1'b0; select = '0;
      ch_ready = 4'b0100;
      for (int i = 2; i <= 5; i++) begin
         check("stall_drain_valid", ch_valid[2], 1);
         check("stall_drain_data", ch_data[2*DW +: DW], i);
         check("stall_drain_addr", ch_addr[2*AW +: AW], 32'h20 + i);
         tick();
      end
      ch_ready = '0;
      check("stall_empty", ch_valid[2], 0);
      check("stall_ovf", ovf_count, 0);

      // Dropped write: single-cycle strobe into a full FIFO, then release.
      do_reset();
      for (int i = 0; i < 4; i++) write(1, 32'd100 + i, 32'h50 + i);
      tick();
      w = 1'b1; select = 4'b0010; wdata = 32'd99; waddr = 32'h99;
      #2;
      check("drop_busy", busy, 1);
      tick();
      w = 1'b0; select = '0;
      tick();
      check("drop_ovf", ovf_count, OVF_EN ? 16'd1 : 16'd0);
      ch_ready = 4'b0010;
      for (int i = 0; i < 4; i++) begin
         check("drop_contents", ch_data[1*DW +: DW], 32'd100 + i);
         tick();
      end
      ch_ready = '0;
      check("drop_empty", ch_valid[1], 0);

      // Asynchronous reset mid-cycle discards queued entries.
      do_reset();
      for (int i = 0; i < 3; i++) write(0, 32'd200 + i, 32'h60 + i);
      check("arst_pre_valid", ch_valid[0], 1);
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("arst_valid_now", ch_valid, '0);
      tick();
      rst = 1'b1;
      tick();
      check("arst_valid_after", ch_valid, '0);
      write(0, 32'h1234, 32'h70);
      check("arst_new_head", ch_data[0 +: DW], 32'h1234);
      ch_ready = 4'b0001;
      tick();
      ch_ready = '0;
      check("arst_single_entry", ch_valid[0], 0);

      // Randomized traffic against the reference model.
      do_reset();
      for (int i = 0; i < 3000; i++) rnd_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
